// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB definitions. Provides the bus address width, the
//               PPROT derivation helper, the requester FSM state encoding
//               and the packed command record used by the requester FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // Requester bus-sequencing states
    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_SETUP   = 2'd1,
        REQ_ACCESS  = 2'd2,
        REQ_RECOVER = 2'd3
    } req_state_e;

    // One queued bus command
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } apb_cmd_t;

    // Protection attributes follow the address map: the top address bit
    // marks the privileged region, the next bit the non-secure region.
    // All requester traffic is data access, so PPROT[2] is always 0.
    function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
        getPprot = {1'b0, addr[ADDR_WIDTH-2], addr[ADDR_WIDTH-1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
// ============================================================================
// Module      : apb_cmd_fifo
// Description : Synchronous command FIFO of apb_cmd_t entries. DEPTH must be
//               a power of two (>= 2) so pointers wrap naturally. A push
//               while full is accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  apb_cmd_t push_data_i,
    input  logic     pop_i,
    output apb_cmd_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    apb_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic w_do_push;
    logic w_do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign w_do_pop   = pop_i & ~empty_o;
    // A pop frees the head slot first, so a full FIFO can still take a push
    assign w_do_push  = push_i & (~full_o | w_do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Entry storage; contents are only meaningful between push and pop
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_requester.sv
// ============================================================================
// Module      : apb_requester
// Description : APB manager stage. Buffers valid/ready commands in a FIFO,
//               issues them as SETUP/ACCESS transfers (chaining back-to-back
//               commands with PSEL held high) and reports each completion
//               on a single-cycle response pulse.
//               Build option APB_REQ_TIMEOUT_EN: adds the ACCESS-phase
//               timeout counter and the one-cycle REQ_RECOVER state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_requester
    import apb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    // response port
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB bus
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    output logic [2:0]            pprot,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_requester: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 63) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be in 1..63");
    end

    req_state_e            state_q;
    logic                  ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]           pwdata_q;
    logic [2:0]            pprot_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

`ifdef APB_REQ_TIMEOUT_EN
    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_CYCLES - 1);
    logic [5:0]            tmo_cnt_q;
    logic                  rsp_timeout_q;
`endif

    logic     w_push;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    apb_cmd_t w_push_cmd;
    apb_cmd_t w_head;

    assign w_push     = cmd_valid & cmd_ready;
    assign w_push_cmd = {cmd_write, cmd_addr, cmd_wdata};
    // Head is consumed when idle, or on completion of the current ACCESS
    assign w_pop      = ~w_empty & ((state_q == REQ_IDLE) |
                                    ((state_q == REQ_ACCESS) & pready));

    apb_cmd_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i       (pclk),
        .rst_ni      (presetn),
        .push_i      (w_push),
        .push_data_i (w_push_cmd),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Holds cmd_ready low through reset and for the first cycle after it
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cmd_ready = ready_q & ~w_full;

    // Bus sequencer: drives all APB outputs and the response registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= REQ_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                REQ_IDLE: begin
                    if (!w_empty) begin
                        pwrite_q  <= w_head.write;
                        paddr_q   <= w_head.addr;
                        pwdata_q  <= w_head.wdata;
                        pprot_q   <= getPprot(w_head.addr);
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= REQ_SETUP;
`ifdef APB_REQ_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                REQ_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= REQ_ACCESS;
                end
                REQ_ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 32'h0 : prdata;
                        rsp_err_q   <= pslverr;
`ifdef APB_REQ_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        penable_q   <= 1'b0;
                        if (!w_empty) begin
                            // Chained transfer: PSEL stays high into the next SETUP
                            pwrite_q  <= w_head.write;
                            paddr_q   <= w_head.addr;
                            pwdata_q  <= w_head.wdata;
                            pprot_q   <= getPprot(w_head.addr);
                            state_q   <= REQ_SETUP;
`ifdef APB_REQ_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end else begin
                            psel_q  <= 1'b0;
                            state_q <= REQ_IDLE;
                        end
                    end
`ifdef APB_REQ_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        // Abort: release the bus and report a timed-out error
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= 32'h0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= REQ_RECOVER;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 6'd1;
                    end
`endif
                end
                REQ_RECOVER: begin
                    // One bus-idle cycle so the peripheral can leave its error state
                    state_q <= REQ_IDLE;
                end
                default: begin
                    state_q <= REQ_IDLE;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pprot     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef APB_REQ_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
// ============================================================================
// Module      : tb_apb_requester
// Description : Scoreboard bench for apb_requester. Directed commands push
//               their hand-computed responses into a queue; a monitor pops
//               and compares on every rsp_valid and records bus timing.
//               Define APB_REQ_TIMEOUT_EN to also cover the timeout path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_requester;
    import apb_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    logic                  pclk      = 1'b0;
    logic                  presetn   = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_write = 1'b0;
    logic [ADDR_WIDTH-1:0] cmd_addr  = '0;
    logic [31:0]           cmd_wdata = '0;
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [2:0]            pprot;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    always #5 pclk = ~pclk;

    apb_requester #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // ---------------- peripheral model ----------------
    // 16-word register file; unwritten words read 0xA000_000i, word 2 reads
    // 0xDEADBEEF. Misaligned addresses error, address 0x30 never answers.
    logic [31:0] wmem [16];
    logic [15:0] wvalid = '0;
    int          num_ws = 0;
    int          ws_cnt = 0;
    logic        p_mis, p_stuck, p_done;
    logic [3:0]  p_idx;
    logic [31:0] p_word;

    always_comb begin
        p_idx   = paddr[5:2];
        p_mis   = (paddr[1:0] != 2'b00);
        p_stuck = (paddr == 32'h30);
        p_done  = psel && penable && !p_stuck && (ws_cnt == num_ws);
        if (wvalid[p_idx])   p_word = wmem[p_idx];
        else if (p_idx == 2) p_word = 32'hDEADBEEF;
        else                 p_word = 32'hA000_0000 | {28'h0, p_idx};
        pready  = p_done;
        pslverr = p_done && p_mis;
        prdata  = (p_done && !pwrite && !p_mis) ? p_word : 32'h0;
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) ws_cnt <= ws_cnt + 1;
        else                            ws_cnt <= 0;
        if (p_done && pwrite && !p_mis) begin
            wmem[p_idx]   <= pwdata;
            wvalid[p_idx] <= 1'b1;
        end
    end

    // ---------------- checking infrastructure ----------------
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    exp_t sb [$];
    int   rsp_cyc [$];

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no event, want event", name);
    endtask

    // ---------------- monitor ----------------
    logic        psel_d = 1'b0, pen_d = 1'b0;
    int          n_psel_rise = 0, n_psel_fall = 0, n_setup = 0, n_rsp = 0;
    int          t_psel = 0, t_pen = 0, t_fall = -1, last_gap = -1;
    int          acc_run = 0, last_acc_len = 0;
    logic [2:0]  last_pprot = '0;
    logic [31:0] last_paddr = '0;
    logic        saw_not_ready = 1'b0;

    always @(negedge pclk) begin
        exp_t e;
        if (psel && !psel_d) begin
            n_psel_rise++;
            t_psel     = cyc;
            last_pprot = pprot;
            last_paddr = paddr;
            if (t_fall >= 0) last_gap = cyc - t_fall;
        end
        if (!psel && psel_d) begin
            n_psel_fall++;
            t_fall = cyc;
        end
        if (penable && !pen_d) t_pen = cyc;
        if (penable) acc_run++;
        else begin
            if (pen_d) last_acc_len = acc_run;
            acc_run = 0;
        end
        if (psel && !penable) n_setup++;
        if (presetn && !cmd_ready) saw_not_ready = 1'b1;
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b tmo %0b, want no response",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                e = sb.pop_front();
                chk("rsp{rdata,err,tmo}", {30'b0, rsp_rdata, rsp_err, rsp_timeout}, {30'b0, e});
            end
        end
        psel_d = psel;
        pen_d  = penable;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic wr, input logic [ADDR_WIDTH-1:0] a, input logic [31:0] wd,
                        input logic [31:0] xr, input logic xe, input logic xt, output int acc);
        int k;
        k = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        while (!cmd_ready && k < 200) begin
            @(negedge pclk);
            k++;
        end
        acc = cyc;
        if (!cmd_ready) fail_now("cmd_accept");
        else sb.push_back('{xr, xe, xt});
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k;
        k = 0;
        while (n_rsp < target && k < budget) begin
            @(negedge pclk);
            #1;
            k++;
        end
        if (n_rsp < target) fail_now("rsp_wait");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, base_rsp, base_fall, base_setup, base_rise, k;

        // Reset state
        repeat (3) @(negedge pclk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait read of 0x8
        base_rsp = n_rsp;
        send(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, c0);
        wait_rsp(base_rsp + 1, 50);
        chk("rd8_psel_latency", t_psel - c0, 2);
        chk("rd8_penable_latency", t_pen - c0, 3);
        chk("rd8_rsp_latency", rsp_cyc[base_rsp] - c0, 4);
        chk("rd8_pprot", last_pprot, 3'b000);

        // Write then read of 0x4, chained
        base_rsp   = n_rsp;
        base_fall  = n_psel_fall;
        base_setup = n_setup;
        base_rise  = n_psel_rise;
        send(1'b1, 32'h4, 32'h12345678, 32'h0, 1'b0, 1'b0, c0);
        send(1'b0, 32'h4, 32'h0, 32'h12345678, 1'b0, 1'b0, c1);
        wait_rsp(base_rsp + 2, 50);
        chk("chain_accept_back_to_back", c1 - c0, 1);
        chk("chain_psel_rises", n_psel_rise - base_rise, 1);
        chk("chain_psel_falls", n_psel_fall - base_fall, 1);
        chk("chain_setup_cycles", n_setup - base_setup, 2);
        chk("chain_rsp_spacing", rsp_cyc[base_rsp + 1] - rsp_cyc[base_rsp], 2);

        // PPROT from a privileged non-secure address
        base_rsp = n_rsp;
        send(1'b1, 32'hC000_0028, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, c0);
        wait_rsp(base_rsp + 1, 50);
        chk("pprot_priv_ns", last_pprot, 3'b011);
        send(1'b0, 32'hC000_0028, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, c0);
        wait_rsp(base_rsp + 2, 50);

        // Three wait states, six queued reads
        num_ws        = 3;
        saw_not_ready = 1'b0;
        base_rsp      = n_rsp;
        send(1'b0, 32'h0C, 32'h0, 32'hA000_0003, 1'b0, 1'b0, c0);
        send(1'b0, 32'h10, 32'h0, 32'hA000_0004, 1'b0, 1'b0, c1);
        send(1'b0, 32'h14, 32'h0, 32'hA000_0005, 1'b0, 1'b0, c1);
        send(1'b0, 32'h18, 32'h0, 32'hA000_0006, 1'b0, 1'b0, c1);
        send(1'b0, 32'h1C, 32'h0, 32'hA000_0007, 1'b0, 1'b0, c1);
        send(1'b0, 32'h20, 32'h0, 32'hA000_0008, 1'b0, 1'b0, c1);
        wait_rsp(base_rsp + 6, 300);
        chk("ws_cmd_ready_fell", saw_not_ready, 1);
        chk("ws_first_rsp_latency", rsp_cyc[base_rsp] - c0, 7);
        num_ws = 0;

        // Misaligned address forwarded, slave error reported
        base_rsp = n_rsp;
        send(1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, c0);
        wait_rsp(base_rsp + 1, 50);
        chk("misaligned_paddr", last_paddr, 32'h6);

`ifdef APB_REQ_TIMEOUT_EN
        // Stuck peripheral: abort after 16 ACCESS cycles, then recover
        base_rsp = n_rsp;
        send(1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1'b1, c0);
        send(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, c1);
        wait_rsp(base_rsp + 1, 60);
        chk("tmo_access_cycles", last_acc_len, 16);
        wait_rsp(base_rsp + 2, 60);
        chk("tmo_psel_low_gap", last_gap, 2);
`endif

        // Reset in the middle of a stalled ACCESS with commands queued
        send(1'b0, 32'h30, 32'h0, 32'h0, 1'b1, 1'b1, c0);
        send(1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, c1);
        send(1'b0, 32'hC, 32'h0, 32'hA000_0003, 1'b0, 1'b0, c1);
        k = 0;
        while (!penable && k < 50) begin
            @(negedge pclk);
            #1;
            k++;
        end
        if (!penable) fail_now("reset_wait_access");
        presetn = 1'b0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        sb.delete();
        base_rise = n_psel_rise;
        base_rsp  = n_rsp;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (6) @(negedge pclk);
        #1;
        chk("midrst_no_new_transfer", n_psel_rise - base_rise, 0);
        chk("midrst_no_response", n_rsp - base_rsp, 0);
        chk("midrst_cmd_ready_after", cmd_ready, 1);

        // Everything expected must have been seen
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge pclk);
            #1;
            k++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
